// File: rtl/rom_stream_reader_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rom_stream_reader_if                                         |
// | Description : Bundle of the rom_stream_reader command, ROM and stream       |
// |               signals.                                                     |
// |   Command : start, base_addr, length, loop, abort  (into the reader)       |
// |   Status  : busy, done                              (out of the reader)    |
// |   ROM     : rom_addr (out), rom_data (in, combinational read data)         |
// |   Stream  : out_valid, out_data, out_last (out), out_ready (in)            |
// |   master  = reader side, slave = controller / ROM / downstream side        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface rom_stream_reader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 4
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] length;
  logic              loop;
  logic              abort;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;
  logic              done;

  modport master (
    input  start, base_addr, length, loop, abort, rom_data, out_ready,
    output rom_addr, out_valid, out_data, out_last, busy, done
  );

  modport slave (
    output start, base_addr, length, loop, abort, rom_data, out_ready,
    input  rom_addr, out_valid, out_data, out_last, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/rom_stream_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rom_stream_reader                                            |
// | Description : Walks a window of ROM addresses, captures the combinational  |
// |               ROM data into an output register and streams it over a       |
// |               valid/ready port. One-shot or looped playback, with abort.   |
// |   clk   : clock, rising edge                                               |
// |   rst_n : asynchronous active-low reset                                    |
// |   bus   : rom_stream_reader_if.master (command, status, ROM, stream)       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rom_stream_reader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 4,
  parameter int DEPTH  = 8
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  rom_stream_reader_if.master  bus
);

  // DEPTH is a power of two, so modulo-DEPTH wrap is a mask of the low bits.
  localparam logic [ADDR_W-1:0] c_addr_mask = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] c_one       = ADDR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_rom_addr;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_len;
  logic [ADDR_W-1:0] r_rem;
  logic              r_loop;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_last;
  logic              r_busy;
  logic              r_done;

  logic              w_load;
  logic              w_accept;
  logic              w_pass_end;
  logic [ADDR_W-1:0] w_next_addr;
  logic [ADDR_W-1:0] w_base_idx;

  // The output register refills whenever it is empty or being drained this
  // cycle, which gives one word per cycle under continuous ready.
  assign w_load      = (!r_out_valid || bus.out_ready) && (r_state == S_RUN);
  assign w_accept    = r_out_valid && bus.out_ready;
  assign w_pass_end  = (r_rem == c_one);
  assign w_next_addr = (r_rom_addr + c_one) & c_addr_mask;
  assign w_base_idx  = bus.base_addr & c_addr_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rom_addr  <= '0;
      r_base      <= '0;
      r_len       <= '0;
      r_rem       <= '0;
      r_loop      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.abort) begin
        // A word handshaking in the same cycle is treated as consumed; the
        // address register keeps its value.
        r_state     <= S_IDLE;
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
        r_busy      <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.start && (bus.length != '0)) begin
              r_base     <= w_base_idx;
              r_len      <= bus.length;
              r_loop     <= bus.loop;
              r_rom_addr <= w_base_idx;
              r_rem      <= bus.length;
              r_busy     <= 1'b1;
              r_state    <= S_RUN;
            end
          end
          S_RUN: begin
            if (w_load) begin
              r_out_data  <= bus.rom_data;
              r_out_valid <= 1'b1;
              r_out_last  <= w_pass_end;
              if (w_pass_end && r_loop) begin
                // Restart the window directly so looping has no bubble.
                r_rom_addr <= r_base;
                r_rem      <= r_len;
              end else begin
                r_rom_addr <= w_next_addr;
                r_rem      <= r_rem - c_one;
                if (w_pass_end) begin
                  r_state <= S_DRAIN;
                end
              end
            end
          end
          S_DRAIN: begin
            if (w_accept) begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_state     <= S_IDLE;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.rom_addr  = r_rom_addr;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule
`default_nettype wire
